// File: rtl/rf_write_sched_pkg.sv
// Shared widths and the packed MDU result record for the RF write scheduler.
package rf_write_sched_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } md_result_t;
endpackage

// File: rtl/rf_wsched_fifo.sv
// DEPTH-entry synchronous FIFO holding MDU results waiting for the RF write port.
module rf_wsched_fifo
  import rf_write_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  md_result_t                 din,
  input  logic                       pop,
  output md_result_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  md_result_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/rf_write_sched.sv
// Arbitrates the RF write port between WB (priority) and buffered MDU results,
// and tracks pending MDU destinations. Optional same-cycle bypass: RF_WRITE_SCHED_BYPASS_EN.
module rf_write_sched
  import rf_write_sched_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_wa_i,
  input  logic [31:0] wb_wd_i,
  input  logic        md_issue_i,
  input  logic [4:0]  md_issue_wa_i,
  input  logic        md_valid_i,
  input  logic [4:0]  md_wa_i,
  input  logic [31:0] md_wd_i,
  output logic        md_ready_o,
  input  logic [4:0]  dec_ra1_i,
  input  logic [4:0]  dec_ra2_i,
  input  logic [4:0]  dec_wa_i,
  output logic        stall_o,
  output logic        hold_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wa_o,
  output logic [31:0] rf_wd_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  md_result_t          head;
  md_result_t          md_in;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                accept;
  logic                drain;
  logic                bypass;
  logic                enq;
  logic [REG_NUM-1:0]  pending;
  logic [REG_NUM-1:0]  pend_set;
  logic [REG_NUM-1:0]  pend_clr;
  logic [3:0]          starve_cnt;
  logic [3:0]          starve_nxt;

  assign md_in      = '{wa: md_wa_i, wd: md_wd_i};
  assign md_ready_o = (count != CW'(DEPTH));
  assign accept     = md_valid_i & ~full;
  assign drain      = ~wb_we_i & ~empty;

`ifdef RF_WRITE_SCHED_BYPASS_EN
  // Gated by rst so nothing reaches the RF port while the block is in reset.
  assign bypass = accept & empty & ~wb_we_i & (md_wa_i != '0) & ~rst;
`else
  assign bypass = 1'b0;
`endif

  assign enq = accept & (md_wa_i != '0) & ~bypass;

  rf_wsched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .din   (md_in),
    .pop   (drain),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rf_we_o = 1'b0;
    rf_wa_o = '0;
    rf_wd_o = '0;
    if (wb_we_i) begin
      rf_we_o = 1'b1;
      rf_wa_o = wb_wa_i;
      rf_wd_o = wb_wd_i;
    end else if (!empty) begin
      rf_we_o = 1'b1;
      rf_wa_o = head.wa;
      rf_wd_o = head.wd;
    end else if (bypass) begin
      rf_we_o = 1'b1;
      rf_wa_o = md_wa_i;
      rf_wd_o = md_wd_i;
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (drain)  pend_clr[head.wa] = 1'b1;
    if (bypass) pend_clr[md_wa_i] = 1'b1;
    if (md_issue_i && (md_issue_wa_i != '0)) pend_set[md_issue_wa_i] = 1'b1;
  end

  // A fresh issue to a register retiring this cycle must stay pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~pend_clr) | pend_set;
  end

  assign stall_o = (pending[dec_ra1_i] & (dec_ra1_i != '0))
                 | (pending[dec_ra2_i] & (dec_ra2_i != '0))
                 | (pending[dec_wa_i]  & (dec_wa_i  != '0))
                 | (md_issue_i & pending[md_issue_wa_i] & (md_issue_wa_i != '0));

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || drain)                   starve_nxt = '0;
    else if (starve_cnt != 4'(STARVE_MAX)) starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      hold_o     <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      hold_o     <= (starve_nxt == 4'(STARVE_MAX));
    end
  end
endmodule

// File: tb/tb_rf_write_sched.sv
// Randomised plus directed bench for rf_write_sched against a queue-based model.
module tb_rf_write_sched;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        md_issue;
  logic [4:0]  md_issue_wa;
  logic        md_valid;
  logic [4:0]  md_wa;
  logic [31:0] md_wd;
  logic        md_ready;
  logic [4:0]  dec_ra1;
  logic [4:0]  dec_ra2;
  logic [4:0]  dec_wa;
  logic        stall;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_write_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_we_i       (wb_we),
    .wb_wa_i       (wb_wa),
    .wb_wd_i       (wb_wd),
    .md_issue_i    (md_issue),
    .md_issue_wa_i (md_issue_wa),
    .md_valid_i    (md_valid),
    .md_wa_i       (md_wa),
    .md_wd_i       (md_wd),
    .md_ready_o    (md_ready),
    .dec_ra1_i     (dec_ra1),
    .dec_ra2_i     (dec_ra2),
    .dec_wa_i      (dec_wa),
    .stall_o       (stall),
    .hold_o        (hold),
    .rf_we_o       (rf_we),
    .rf_wa_o       (rf_wa),
    .rf_wd_o       (rf_wd)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  bit   pend[32];
  int   starve;
  bit   hold_m;

  function automatic bit bypass_on();
`ifdef RF_WRITE_SCHED_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit          acc, byp, drn, e_stall;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    int          pre_size;
    #1;
    if (rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      starve = 0;
      hold_m = 1'b0;
    end
    acc = md_valid && (q.size() != DEPTH);
    byp = bypass_on() && acc && (q.size() == 0) && !wb_we && (md_wa != 0) && !rst;
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (wb_we)               begin e_we = 1'b1; e_wa = wb_wa;   e_wd = wb_wd;   end
    else if (q.size() > 0)   begin e_we = 1'b1; e_wa = q[0].wa; e_wd = q[0].wd; end
    else if (byp)            begin e_we = 1'b1; e_wa = md_wa;   e_wd = md_wd;   end
    e_stall = (pend[dec_ra1] && dec_ra1 != 0) || (pend[dec_ra2] && dec_ra2 != 0) ||
              (pend[dec_wa] && dec_wa != 0) ||
              (md_issue && pend[md_issue_wa] && md_issue_wa != 0);
    check_val("md_ready", md_ready, (q.size() != DEPTH));
    check_val("rf_we", rf_we, e_we);
    check_val("rf_wa", rf_wa, e_wa);
    check_val("rf_wd", rf_wd, e_wd);
    check_val("stall", stall, e_stall);
    check_val("hold", hold, hold_m);
    @(posedge clk);
    if (!rst) begin
      pre_size = q.size();
      drn = !wb_we && (pre_size > 0);
      if (drn) begin
        pend[q[0].wa] = 1'b0;
        void'(q.pop_front());
      end
      if (byp) pend[md_wa] = 1'b0;
      if (acc && md_wa != 0 && !byp) q.push_back('{wa: md_wa, wd: md_wd});
      if (md_issue && md_issue_wa != 0) pend[md_issue_wa] = 1'b1;
      if (pre_size == 0 || drn) starve = 0;
      else if (starve < SMAX)   starve++;
      hold_m = (starve == SMAX);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    md_issue = 0; md_issue_wa = 0;
    md_valid = 0; md_wa = 0; md_wd = 0;
    dec_ra1 = 0; dec_ra2 = 0; dec_wa = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);

    // Reset with a result presented: must not be taken
    md_valid = 1; md_wa = 7; md_wd = 32'hdead_beef;
    #1;
    check_val("rst_ready", md_ready, 1);
    check_val("rst_rf_we", rf_we, 0);
    check_val("rst_stall", stall, 0);
    cycle();
    cycle();
    rst = 1'b0;
    idle();
    cycle();

    // Issue to $8, then its result
    md_issue = 1; md_issue_wa = 8;
    cycle();
    idle();
    md_valid = 1; md_wa = 8; md_wd = 32'h0000_1234; dec_ra1 = 8;
    #1;
    check_val("s2_stall_before", stall, 1);
    if (bypass_on()) begin
      check_val("s2_byp_we", rf_we, 1);
      check_val("s2_byp_wa", rf_wa, 8);
      check_val("s2_byp_wd", rf_wd, 32'h1234);
    end
    cycle();
    idle();
    dec_ra1 = 8;
    if (!bypass_on()) begin
      #1;
      check_val("s2_we", rf_we, 1);
      check_val("s2_wa", rf_wa, 8);
      check_val("s2_wd", rf_wd, 32'h1234);
      cycle();
      idle();
      dec_ra1 = 8;
    end
    #1;
    check_val("s2_stall_after", stall, 0);
    cycle();

    // WB busy while two results fill the buffer
    wb_we = 1; wb_wa = 3; wb_wd = 32'h3333;
    md_issue = 1; md_issue_wa = 9;
    cycle();
    md_issue_wa = 10;
    cycle();
    md_issue = 0;
    md_valid = 1; md_wa = 9; md_wd = 32'h9999;
    cycle();
    md_wa = 10; md_wd = 32'haaaa;
    cycle();
    md_wa = 11; md_wd = 32'hbbbb;
    #1;
    check_val("s3_not_ready", md_ready, 0);
    check_val("s3_rf_wa", rf_wa, 3);
    cycle();
    md_valid = 0;
    repeat (4) cycle();
    #1;
    check_val("s4_hold", hold, 1);
    wb_we = 0;
    #1;
    check_val("s4_drain1", rf_wa, 9);
    cycle();
    #1;
    check_val("s4_drain2", rf_wa, 10);
    check_val("s4_hold_clr", hold, 0);
    cycle();
    idle();
    cycle();

    // Re-issue to $5 on the cycle its previous result retires
    md_issue = 1; md_issue_wa = 5;
    cycle();
    idle();
    md_valid = 1; md_wa = 5; md_wd = 32'h5555;
    if (bypass_on()) begin
      md_issue = 1; md_issue_wa = 5;
    end
    cycle();
    if (!bypass_on()) begin
      idle();
      md_issue = 1; md_issue_wa = 5;
      cycle();
    end
    idle();
    dec_ra1 = 5;
    #1;
    check_val("s5_pending5", stall, 1);
    cycle();

    // Zero destination: accepted and dropped
    idle();
    md_valid = 1; md_wa = 0; md_wd = 32'h0bad;
    #1;
    check_val("s6_ready", md_ready, 1);
    check_val("s6_rf_we", rf_we, 0);
    cycle();
    idle();
    md_issue = 1; md_issue_wa = 0;
    cycle();
    idle();
    #1;
    check_val("s6_rf_we_after", rf_we, 0);
    cycle();

    // Random traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      wb_we       = ($urandom % 3) == 0;
      wb_wa       = 5'($urandom_range(0, 31));
      wb_wd       = $urandom;
      md_issue    = ($urandom % 3) == 0;
      md_issue_wa = 5'($urandom_range(0, 7));
      md_valid    = ($urandom % 2) == 0;
      md_wa       = 5'($urandom_range(0, 7));
      md_wd       = $urandom;
      dec_ra1     = 5'($urandom_range(0, 7));
      dec_ra2     = 5'($urandom_range(0, 7));
      dec_wa      = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Schedules the single register-file write port between two sources: the in-order pipeline writeback, which always has priority, and results from a multi-cycle mul/div unit (MDU), which arrive out of order and are buffered.
- Keeps a 32-entry scoreboard of registers with an MDU result still pending. Decode uses it to stall RAW/WAW hazards.
- Sits between the WB stage, the MDU result port and the register file's write port (we/wa/wd).

Parameters:
- DEPTH, 2, number of MDU result buffer entries (power of two, 2..8)
- STARVE_MAX, 4, cycles the buffer head may wait before hold_o asserts (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wb_we_i  in  1  pipeline WB write enable
- wb_wa_i  in  5  pipeline WB destination
- wb_wd_i  in  32  pipeline WB data
- md_issue_i  in  1  MDU op issued this cycle
- md_issue_wa_i  in  5  destination of the issued MDU op
- md_valid_i  in  1  MDU result valid
- md_wa_i  in  5  MDU result destination
- md_wd_i  in  32  MDU result data
- md_ready_o  out  1  buffer can accept an MDU result
- dec_ra1_i  in  5  decode source rs
- dec_ra2_i  in  5  decode source rt
- dec_wa_i  in  5  decode destination (0 = none)
- stall_o  out  1  decode must stall (hazard on a pending register)
- hold_o  out  1  freeze pipeline front end so a WB bubble reaches this block
- rf_we_o  out  1  register-file write enable
- rf_wa_o  out  5  register-file write address
- rf_wd_o  out  32  register-file write data

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. Reset clears the FIFO (count = 0, pointers = 0), the pending vector (all 0) and the starve counter (0).
  - After reset: md_ready_o = 1, stall_o = 0, hold_o = 0, rf_we_o = 0, rf_wa_o = 0, rf_wd_o = 0.
  - Reset mid-operation drops all buffered results and all pending bits.
- Write-port mux (combinational):
  - If wb_we_i = 1, rf_* carries the wb_* inputs.
  - Else if the FIFO is non-empty, rf_* carries the FIFO head with rf_we_o = 1, and the head dequeues at the clock edge (drain).
  - Else rf_we_o = 0, rf_wa_o = 0, rf_wd_o = 0.
- Enqueue: md_ready_o = (count != DEPTH).
  - Accepting (md_valid_i & md_ready_o) with md_wa_i != 0 enqueues at the clock edge.
  - A result with md_wa_i = 0 is accepted and discarded.
  - Latency: accepted at cycle N, earliest RF write is cycle N+1.
  - Enqueue and drain may occur in the same cycle; count is then unchanged.
- Scoreboard:
  - pending[wa] is set at the edge where md_issue_i = 1 and md_issue_wa_i != 0.
  - pending[wa] is cleared at the edge where an MDU write of wa drains to the RF, or is bypassed (see BYPASS_EN).
  - Set and clear of the same register in the same cycle: set wins.
- stall_o (combinational) = (pending[dec_ra1_i] & dec_ra1_i != 0) | (pending[dec_ra2_i] & dec_ra2_i != 0) | (pending[dec_wa_i] & dec_wa_i != 0) | (md_issue_i & pending[md_issue_wa_i] & md_issue_wa_i != 0).
  - This covers RAW, and WAW against a pending MDU result.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and no drain occurs, saturating at STARVE_MAX.
  - It resets to 0 on any drain or when the FIFO is empty.
  - hold_o = (starve_cnt == STARVE_MAX), registered. It stays 1 until the cycle after a drain.
  - While hold_o = 1, the pipeline guarantees a wb_we_i = 0 cycle within 5 cycles. The block does not check this.
- The buffer never overflows: a result presented while md_ready_o = 0 is not accepted, and the MDU must hold it.

Optional Feature:
- Macro: RF_WRITE_SCHED_BYPASS_EN.
- Defined: an accepted MDU result writes the RF in the same cycle (rf_* = md_*, no enqueue, latency 0) when all of the following hold:
  - the FIFO is empty
  - wb_we_i = 0
  - md_wa_i != 0
  The pending bit clears at that edge.
- Undefined: every accepted result goes through the FIFO, with minimum latency 1 cycle.

Decomposition:
- Shared package: REG_ADDR_W = 5, REG_NUM = 32, DATA_W = 32, and the packed MDU result struct {wa[4:0], wd[31:0]}.
- One sub-module, rf_wsched_fifo: a DEPTH-entry synchronous FIFO with count, full and empty, reset asynchronously.
- Scoreboard, mux and starvation logic stay in the top module.

Test Plan:
1. Reset with md_valid_i = 1 held → md_ready_o = 1, rf_we_o = 0, stall_o = 0 while rst = 1; no enqueue.
2. Issue to $8, then MDU result {8, 0x0000_1234} with WB idle → rf_we_o = 1, wa = 8, wd = 0x1234 one cycle later (same cycle under BYPASS_EN); pending[8] clears after it; stall_o on dec_ra1_i = 8 is 1 before the write and 0 after.
3. wb_we_i held 1 (wa = 3) while two MDU results (wa 9 and 10) arrive → md_ready_o = 0 after the 2nd result; the third result is not accepted; RF sees only wa = 3.
4. Continue scenario 3 for 4 more cycles → hold_o = 1; drop wb_we_i → writes to 9 then 10 drain on consecutive cycles; hold_o = 0 the cycle after the first drain.
5. md_issue_i with wa 5 in the same cycle as the drain of the previous wa 5 result → pending[5] stays 1.
6. MDU result with md_wa_i = 0 → accepted, count unchanged, rf_we_o stays 0; md_issue_wa_i = 0 never sets a pending bit.
